// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: shared state encodings and defaults for the hazard sequencer
package pipeline_hazard_ctrl_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, MEM_ABORT = 2'd2} state_e;
  localparam int MEM_TIMEOUT_DEF = 255;
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: 16-bit clear/enable counter flagging the configured terminal count
module mem_wait_timer #(
  parameter logic [15:0] TERM = 16'd254
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  logic [15:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + 16'd1 : cnt_q;
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign tc_o = cnt_q == TERM;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/bubble sequencer for the 5-stage pipeline with timed memory handshake
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             MemRead_EX,
  input  logic [4:0]       WriteReg_EX,
  input  logic [4:0]       Rs_ID,
  input  logic [4:0]       Rt_ID,
  input  logic             UsesRt_ID,
  input  logic             Jump_ID,
  input  logic             Redirect_EX,
  input  logic             MemOp_MEM,
  input  logic             MemAck,
  output logic             PCWrite,
  output logic             IFID_Write,
  output logic             IDEX_Write,
  output logic             EXMEM_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic             MEMWB_Bubble,
  output logic             MemReq,
  output logic             MemTimeout,
  output logic [CNT_W-1:0] StallCycles
);
  state_e state_q, state_d;
  logic tmo_q, tmo_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic tc, mem_stall, load_use, expire;
  // timer runs only while waiting, so its count is the number of MEM_WAIT cycles already spent
  mem_wait_timer #(.TERM(16'(MEM_TIMEOUT - 1))) u_timer (
    .Clk   (Clk),
    .Reset (Reset),
    .clr_i (state_q != MEM_WAIT),
    .en_i  (state_q == MEM_WAIT),
    .tc_o  (tc)
  );
  always_comb begin
    mem_stall = state_q != MEM_ABORT && MemOp_MEM && !MemAck;
    expire = state_q == MEM_WAIT && !MemAck && tc;
    load_use = MemRead_EX && WriteReg_EX != '0 &&
               (WriteReg_EX == Rs_ID || (UsesRt_ID && WriteReg_EX == Rt_ID));
    state_d = state_q == MEM_ABORT ? RUN :
              state_q == MEM_WAIT ? (MemAck ? RUN : expire ? MEM_ABORT : MEM_WAIT) :
              mem_stall ? MEM_WAIT : RUN;
    // reset forces the quiescent output set even though outputs are combinational
    PCWrite = Reset || !(mem_stall || (!Redirect_EX && load_use));
    IFID_Write = PCWrite;
    IDEX_Write = Reset || !mem_stall;
    EXMEM_Write = IDEX_Write;
    IFID_Flush = !Reset && !mem_stall && (Redirect_EX || (!load_use && Jump_ID));
    IDEX_Flush = !Reset && !mem_stall && (Redirect_EX || load_use);
    MEMWB_Bubble = !Reset && (mem_stall || state_q == MEM_ABORT);
    MemReq = !Reset && (state_q == MEM_WAIT || (state_q == RUN && MemOp_MEM));
    tmo_d = tmo_q || expire;
    stall_d = stall_q + CNT_W'(!PCWrite);
  end
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= RUN;
      tmo_q <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      tmo_q <= tmo_d;
      stall_q <= stall_d;
    end
  end
  assign MemTimeout = tmo_q;
  assign StallCycles = stall_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed scoreboard bench for the hazard sequencer
module tb_pipeline_hazard_ctrl;
  typedef struct packed {
    logic [8:0]  f;
    logic [31:0] sc;
  } exp_t;

  localparam logic [8:0] NORM = 9'b1111_00_000;
  localparam logic [8:0] LU   = 9'b0011_01_000;
  localparam logic [8:0] RED  = 9'b1111_11_000;
  localparam logic [8:0] JMP  = 9'b1111_10_000;
  localparam logic [8:0] MST  = 9'b0000_00_110;
  localparam logic [8:0] ROK  = 9'b1111_00_010;
  localparam logic [8:0] ABT  = 9'b1111_00_101;
  localparam logic [8:0] TMO  = 9'b0000_00_001;

  logic Clk = 1'b0, Reset = 1'b1;
  logic MemRead_EX = 0, UsesRt_ID = 0, Jump_ID = 0, Redirect_EX = 0, MemOp_MEM = 0, MemAck = 0;
  logic [4:0] WriteReg_EX = 0, Rs_ID = 0, Rt_ID = 0;
  logic a_pcw, a_ifw, a_idw, a_exw, a_iff, a_idf, a_bub, a_req, a_tmo;
  logic b_pcw, b_ifw, b_idw, b_exw, b_iff, b_idf, b_bub, b_req, b_tmo;
  logic [31:0] a_sc;
  logic [1:0]  b_sc;
  exp_t q[$];
  int n_chk = 0, n_fail = 0;
  int sc_exp = 0;

  always #5 Clk = ~Clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .Clk(Clk), .Reset(Reset), .MemRead_EX(MemRead_EX), .WriteReg_EX(WriteReg_EX),
    .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .UsesRt_ID(UsesRt_ID), .Jump_ID(Jump_ID),
    .Redirect_EX(Redirect_EX), .MemOp_MEM(MemOp_MEM), .MemAck(MemAck),
    .PCWrite(a_pcw), .IFID_Write(a_ifw), .IDEX_Write(a_idw), .EXMEM_Write(a_exw),
    .IFID_Flush(a_iff), .IDEX_Flush(a_idf), .MEMWB_Bubble(a_bub), .MemReq(a_req),
    .MemTimeout(a_tmo), .StallCycles(a_sc)
  );

  // narrow counter copy exercises StallCycles wrap-around
  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(2)) dut_w (
    .Clk(Clk), .Reset(Reset), .MemRead_EX(MemRead_EX), .WriteReg_EX(WriteReg_EX),
    .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .UsesRt_ID(UsesRt_ID), .Jump_ID(Jump_ID),
    .Redirect_EX(Redirect_EX), .MemOp_MEM(MemOp_MEM), .MemAck(MemAck),
    .PCWrite(b_pcw), .IFID_Write(b_ifw), .IDEX_Write(b_idw), .EXMEM_Write(b_exw),
    .IFID_Flush(b_iff), .IDEX_Flush(b_idf), .MEMWB_Bubble(b_bub), .MemReq(b_req),
    .MemTimeout(b_tmo), .StallCycles(b_sc)
  );

  task automatic cyc(input logic r, input logic mr, input logic [4:0] wr, input logic [4:0] rs,
                     input logic [4:0] rt, input logic ur, input logic j, input logic rd,
                     input logic mo, input logic ack, input logic [8:0] f);
    exp_t e;
    @(posedge Clk);
    #1;
    Reset = r; MemRead_EX = mr; WriteReg_EX = wr; Rs_ID = rs; Rt_ID = rt; UsesRt_ID = ur;
    Jump_ID = j; Redirect_EX = rd; MemOp_MEM = mo; MemAck = ack;
    if (r) sc_exp = 0;
    e.f = f;
    e.sc = sc_exp;
    q.push_back(e);
    if (!f[8]) sc_exp++;
  endtask

  always @(negedge Clk) begin
    if (q.size() != 0) begin
      exp_t e;
      logic [8:0] fa, fb;
      e = q.pop_front();
      fa = {a_pcw, a_ifw, a_idw, a_exw, a_iff, a_idf, a_bub, a_req, a_tmo};
      fb = {b_pcw, b_ifw, b_idw, b_exw, b_iff, b_idf, b_bub, b_req, b_tmo};
      n_chk += 3;
      if (fa !== e.f) begin
        n_fail++;
        $display("FAIL flags t=%0t got=%b exp=%b", $time, fa, e.f);
      end
      if (a_sc !== e.sc) begin
        n_fail++;
        $display("FAIL stall_cycles t=%0t got=%0d exp=%0d", $time, a_sc, e.sc);
      end
      if ({fb, b_sc} !== {e.f, e.sc[1:0]}) begin
        n_fail++;
        $display("FAIL narrow_cnt t=%0t got=%b/%0d exp=%b/%0d", $time, fb, b_sc, e.f, e.sc[1:0]);
      end
    end
  end

  initial begin
    //  r  mr wr    rs    rt    ur j  rd mo ack flags
    cyc(1, 1, 5'd8, 5'd8, 5'd0, 0, 1, 0, 1, 0, NORM);
    cyc(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, NORM);
    cyc(0, 1, 5'd8, 5'd8, 5'd0, 0, 0, 0, 0, 0, LU);
    cyc(0, 0, 5'd0, 5'd8, 5'd0, 0, 0, 0, 0, 0, NORM);
    cyc(0, 1, 5'd9, 5'd3, 5'd9, 1, 0, 0, 0, 0, LU);
    cyc(0, 1, 5'd9, 5'd3, 5'd9, 0, 0, 0, 0, 0, NORM);
    cyc(0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0, NORM);
    cyc(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0, JMP);
    cyc(0, 1, 5'd8, 5'd8, 5'd0, 0, 1, 1, 0, 0, RED);
    cyc(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, MST);
    cyc(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, MST);
    cyc(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, ROK);
    cyc(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, NORM);
    cyc(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, ROK);
    cyc(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, NORM);
    cyc(0, 1, 5'd8, 5'd8, 5'd0, 0, 0, 1, 1, 0, MST);
    cyc(0, 1, 5'd8, 5'd8, 5'd0, 0, 0, 1, 1, 1, RED | ROK);
    cyc(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, NORM);
    cyc(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, MST);
    repeat (4) cyc(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, MST);
    cyc(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, ABT);
    cyc(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, NORM | TMO);
    cyc(0, 1, 5'd8, 5'd8, 5'd0, 0, 0, 0, 0, 0, LU | TMO);
    cyc(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, MST | TMO);
    cyc(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, MST | TMO);
    cyc(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, NORM);
    cyc(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, NORM);
    cyc(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0, JMP);
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge Clk);
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
